// File: rtl/alu_pkg.sv
// Shared decode constants, FSM encoding and small helpers for the ALU issue sequencer.
package alu_pkg;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SUB  = 3'b000;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_ADDI = 3'b000;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;
  localparam logic [6:0] F7_XOR = 7'b0000000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    WB     = 3'd4
  } state_t;

  // True only for ADD, SUB, XOR and ADDI; everything else gets dropped.
  function automatic logic is_legal(input logic [31:0] inst);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = inst[6:0];
    f3 = inst[14:12];
    f7 = inst[31:25];
    return ((op == OP_R) && (((f3 == F3_ADD) && (f7 == F7_ADD)) ||
                             ((f3 == F3_SUB) && (f7 == F7_SUB)) ||
                             ((f3 == F3_XOR) && (f7 == F7_XOR)))) ||
           ((op == OP_I) && (f3 == F3_ADDI));
  endfunction

  // I-type immediate widened to a full operand.
  function automatic logic [31:0] sext12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Instruction intake, ALU request/response and writeback signals of the issue sequencer.
// Handshake: an instruction transfers on a rising edge where inst_valid and inst_ready are
// both 1; inst must be stable while inst_valid is high. alu_valid is a one-cycle start
// pulse and alu_out is taken on the edge where alu_ready is 1 while the sequencer waits.
// wb_valid is a one-cycle commit pulse qualifying wb_rd and wb_data.
interface alu_issue_if;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic        alu_valid;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_funct3;
  logic [6:0]  alu_funct7;
  logic [31:0] alu_in_A;
  logic [31:0] alu_in_B;
  logic        alu_ready;
  logic [31:0] alu_out;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  // Sequencer side.
  modport master (
    input  inst_valid, inst, alu_ready, alu_out,
    output inst_ready, alu_valid, alu_opcode, alu_funct3, alu_funct7,
           alu_in_A, alu_in_B, wb_valid, wb_rd, wb_data
  );

  // Environment side: instruction source, ALU and writeback observer.
  modport slave (
    output inst_valid, inst, alu_ready, alu_out,
    input  inst_ready, alu_valid, alu_opcode, alu_funct3, alu_funct7,
           alu_in_A, alu_in_B, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/reg_file.sv
// 32x32 register file: two operand read ports, a debug read port and one write port.
// x0 always reads zero and writes to it are dropped.
module reg_file (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_addr,
  output logic [31:0] rs1_data,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs2_data,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  input  logic        we,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data
);
  logic [31:0] regs [32];

  // Clear everything on reset; otherwise commit one write per cycle, never to x0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (wr_addr != 5'd0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];
endmodule

// File: rtl/alu_issue.sv
// Issue/writeback sequencer in front of a multi-cycle ALU: takes one instruction at a
// time, reads operands, starts the ALU, waits with a watchdog and writes the result back.
module alu_issue
  import alu_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_if.master bus,
  output logic        illegal,
  output logic        timeout,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output state_t      dbg_state
);
  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] inst_q;
  logic [31:0] op_a_q;
  logic [31:0] op_b_q;
  logic [31:0] wb_data_q;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [6:0]  opcode_q;
  logic [6:0]  funct7_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;
  logic [7:0]  wait_cnt;
  logic        legal;
  logic        rf_we;

  assign legal = is_legal(inst_q);

  reg_file u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (inst_q[19:15]),
    .rs1_data (rs1_data),
    .rs2_addr (inst_q[24:20]),
    .rs2_data (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (rf_we),
    .wr_addr  (rd_q),
    .wr_data  (wb_data_q)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and the per-state pulses; alu_ready wins over a coinciding expiry.
  always_comb begin
    state_nxt      = state;
    bus.inst_ready = 1'b0;
    bus.alu_valid  = 1'b0;
    bus.wb_valid   = 1'b0;
    illegal        = 1'b0;
    timeout        = 1'b0;
    rf_we          = 1'b0;
    case (state)
      IDLE: begin
        bus.inst_ready = 1'b1;
        if (bus.inst_valid) state_nxt = DECODE;
      end
      DECODE: begin
        if (legal) begin
          state_nxt = ISSUE;
        end else begin
          illegal   = 1'b1;
          state_nxt = IDLE;
        end
      end
      ISSUE: begin
        bus.alu_valid = 1'b1;
        state_nxt     = WAIT;
      end
      WAIT: begin
        if (bus.alu_ready) begin
          state_nxt = WB;
        end else if (wait_cnt == WAIT_LIMIT) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WB: begin
        bus.wb_valid = 1'b1;
        rf_we        = (rd_q != 5'd0);
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch the instruction, operands, watchdog count and ALU result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q    <= '0;
      opcode_q  <= '0;
      funct3_q  <= '0;
      funct7_q  <= '0;
      rd_q      <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      wait_cnt  <= '0;
      wb_data_q <= '0;
    end else begin
      if ((state == IDLE) && bus.inst_valid) inst_q <= bus.inst;
      if ((state == DECODE) && legal) begin
        opcode_q <= inst_q[6:0];
        funct3_q <= inst_q[14:12];
        funct7_q <= inst_q[31:25];
        rd_q     <= inst_q[11:7];
        op_a_q   <= rs1_data;
        op_b_q   <= (inst_q[6:0] == OP_I) ? sext12(inst_q[31:20]) : rs2_data;
      end
      if (state == ISSUE)     wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 8'd1;
      if ((state == WAIT) && bus.alu_ready) wb_data_q <= bus.alu_out;
    end
  end

  assign bus.alu_opcode = opcode_q;
  assign bus.alu_funct3 = funct3_q;
  assign bus.alu_funct7 = funct7_q;
  assign bus.alu_in_A   = op_a_q;
  assign bus.alu_in_B   = op_b_q;
  assign bus.wb_rd      = rd_q;
  assign bus.wb_data    = wb_data_q;
  assign dbg_state      = state;
endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed vector table, hand-written reset sequence and random
// instructions checked against an architectural register model.
module tb_alu_issue;
  import alu_pkg::*;

  localparam int MAX_WAIT = 16;

  typedef struct {
    logic [31:0] inst;
    int          k;
    logic        noise;
    logic        keep;
    logic        ill;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        illegal;
  logic        timeout;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  state_t      dbg_state;
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] model [32];
  vec_t        tbl [13];

  alu_issue_if bus ();

  alu_issue #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .illegal   (illegal),
    .timeout   (timeout),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .dbg_state (dbg_state)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_time_limit: got no end expected end");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference decode: 0 ADD, 1 SUB, 2 XOR, 3 ADDI, -1 illegal.
  function automatic int op_kind(input logic [31:0] w);
    if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'h00) return 0;
    if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'h20) return 1;
    if (w[6:0] == 7'h33 && w[14:12] == 3'd4 && w[31:25] == 7'h00) return 2;
    if (w[6:0] == 7'h13 && w[14:12] == 3'd0) return 3;
    return -1;
  endfunction

  // Driver + checker for one instruction. Acts as the ALU: returns e_res k cycles after
  // the start pulse (k=0: never). Entered and left on the falling edge.
  task automatic run_txn(input string tag, input logic [31:0] w, input int k,
                         input logic noise, input logic keep, input logic [31:0] next_w,
                         input logic e_ill, input logic [31:0] e_a, input logic [31:0] e_b,
                         input logic [31:0] e_res);
    int ill_cyc = -1;
    int av_cyc = -1;
    int av_cnt = 0;
    int wb_cyc = -1;
    int to_cyc = -1;
    int ret = -1;
    int e_ill_cyc, e_av_cyc, e_wb_cyc, e_to_cyc, e_ret;
    logic writes = 1'b0;
    logic [31:0] s_a = '0;
    logic [31:0] s_b = '0;
    logic [31:0] s_wbd = '0;
    logic [6:0] s_op = '0;
    logic [6:0] s_f7 = '0;
    logic [2:0] s_f3 = '0;
    logic [4:0] s_rd = '0;
    logic [4:0] rd;
    rd = w[11:7];
    bus.inst_valid = 1'b1;
    bus.inst = w;
    for (int c = 0; c < 80 && ret < 0; c++) begin
      if (c == 1) begin
        if (keep) bus.inst = next_w;
        else bus.inst_valid = 1'b0;
      end
      bus.alu_ready = (k > 0 && c == 2 + k) || (noise && c == 2);
      bus.alu_out = (k > 0 && c == 2 + k) ? e_res : $urandom;
      #1;
      if (c == 0) chk({tag, " ready_idle"}, 32'(bus.inst_ready), 1);
      if (illegal && ill_cyc < 0) ill_cyc = c;
      if (timeout && to_cyc < 0) to_cyc = c;
      if (bus.alu_valid) begin
        av_cnt++;
        if (av_cyc < 0) begin
          av_cyc = c;
          s_a = bus.alu_in_A;
          s_b = bus.alu_in_B;
          s_op = bus.alu_opcode;
          s_f3 = bus.alu_funct3;
          s_f7 = bus.alu_funct7;
        end
      end
      if (bus.wb_valid && wb_cyc < 0) begin
        wb_cyc = c;
        s_rd = bus.wb_rd;
        s_wbd = bus.wb_data;
      end
      if (c >= 1 && bus.inst_ready) ret = c;
      else @(negedge clk);
    end
    bus.alu_ready = 1'b0;
    if (e_ill) begin
      e_ill_cyc = 1; e_av_cyc = -1; e_wb_cyc = -1; e_to_cyc = -1; e_ret = 2;
    end else if (k >= 1 && k <= MAX_WAIT + 1) begin
      e_ill_cyc = -1; e_av_cyc = 2; e_wb_cyc = 3 + k; e_to_cyc = -1; e_ret = 4 + k;
      writes = 1'b1;
    end else begin
      e_ill_cyc = -1; e_av_cyc = 2; e_wb_cyc = -1; e_to_cyc = 3 + MAX_WAIT;
      e_ret = 4 + MAX_WAIT;
    end
    chk({tag, " ready_again_cycle"}, ret, e_ret);
    chk({tag, " illegal_cycle"}, ill_cyc, e_ill_cyc);
    chk({tag, " alu_valid_cycle"}, av_cyc, e_av_cyc);
    chk({tag, " alu_valid_count"}, av_cnt, e_ill ? 0 : 1);
    chk({tag, " wb_valid_cycle"}, wb_cyc, e_wb_cyc);
    chk({tag, " timeout_cycle"}, to_cyc, e_to_cyc);
    if (!e_ill) begin
      chk({tag, " alu_in_A"}, s_a, e_a);
      chk({tag, " alu_in_B"}, s_b, e_b);
      chk({tag, " alu_opcode"}, 32'(s_op), 32'(w[6:0]));
      chk({tag, " alu_funct3"}, 32'(s_f3), 32'(w[14:12]));
      chk({tag, " alu_funct7"}, 32'(s_f7), 32'(w[31:25]));
      chk({tag, " alu_in_A_held"}, bus.alu_in_A, e_a);
    end
    if (writes) begin
      chk({tag, " wb_rd"}, 32'(s_rd), 32'(rd));
      chk({tag, " wb_data"}, s_wbd, e_res);
      if (rd != 5'd0) model[rd] = e_res;
    end
    dbg_addr = rd;
    #1;
    chk({tag, " regfile_rd"}, dbg_data, model[rd]);
  endtask

  initial begin
    int wb_seen;
    for (int r = 0; r < 32; r++) model[r] = '0;
    bus.inst_valid = 1'b0;
    bus.inst = '0;
    bus.alu_ready = 1'b0;
    bus.alu_out = '0;
    dbg_addr = 5'd1;

    // Reset state.
    #2;
    chk("reset inst_ready", 32'(bus.inst_ready), 1);
    chk("reset alu_valid", 32'(bus.alu_valid), 0);
    chk("reset wb_valid", 32'(bus.wb_valid), 0);
    chk("reset illegal", 32'(illegal), 0);
    chk("reset timeout", 32'(timeout), 0);
    chk("reset wb_rd", 32'(bus.wb_rd), 0);
    chk("reset wb_data", bus.wb_data, 0);
    chk("reset alu_in_B", bus.alu_in_B, 0);
    chk("reset x1", dbg_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors: inst, k, noise, keep, illegal, A, B, ALU result.
    tbl[0]  = '{32'h00500093, 2,  1'b0, 1'b0, 1'b0, 32'h0, 32'h5, 32'h5};
    tbl[1]  = '{32'hFFF00113, 1,  1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[2]  = '{32'h002081B3, 3,  1'b1, 1'b0, 1'b0, 32'h5, 32'hFFFFFFFF, 32'h4};
    tbl[3]  = '{32'h40208233, 2,  1'b0, 1'b1, 1'b0, 32'h5, 32'hFFFFFFFF, 32'h6};
    tbl[4]  = '{32'h0020C2B3, 1,  1'b0, 1'b0, 1'b0, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFFA};
    tbl[5]  = '{32'h0020E3B3, 2,  1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0};
    tbl[6]  = '{32'h00109093, 2,  1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0};
    tbl[7]  = '{32'h4020C2B3, 2,  1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0};
    tbl[8]  = '{32'h00108033, 2,  1'b0, 1'b0, 1'b0, 32'h5, 32'h5, 32'hA};
    tbl[9]  = '{32'h00208333, 0,  1'b1, 1'b0, 1'b0, 32'h5, 32'hFFFFFFFF, 32'h4};
    tbl[10] = '{32'h00208333, 17, 1'b0, 1'b0, 1'b0, 32'h5, 32'hFFFFFFFF, 32'h4};
    tbl[11] = '{32'h00700413, 18, 1'b0, 1'b0, 1'b0, 32'h0, 32'h7, 32'h7};
    tbl[12] = '{32'h80030493, 16, 1'b0, 1'b0, 1'b0, 32'h4, 32'hFFFFF800, 32'hFFFFF804};
    for (int i = 0; i < 13; i++) begin
      run_txn($sformatf("vec%0d", i), tbl[i].inst, tbl[i].k, tbl[i].noise, tbl[i].keep,
              (i < 12) ? tbl[i + 1].inst : 32'h0, tbl[i].ill, tbl[i].a, tbl[i].b,
              tbl[i].res);
    end

    // Reset while waiting on the ALU: instruction abandoned, late alu_ready ignored.
    @(negedge clk);
    bus.inst_valid = 1'b1;
    bus.inst = 32'h00208333;
    @(negedge clk);
    bus.inst_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_mid in_wait", 32'(dbg_state), 32'(WAIT));
    chk("rst_mid alu_in_A_before", bus.alu_in_A, 32'h5);
    rst_n = 1'b0;
    #1;
    chk("rst_mid inst_ready", 32'(bus.inst_ready), 1);
    chk("rst_mid alu_in_A", bus.alu_in_A, 0);
    chk("rst_mid alu_in_B", bus.alu_in_B, 0);
    chk("rst_mid alu_opcode", 32'(bus.alu_opcode), 0);
    chk("rst_mid wb_data", bus.wb_data, 0);
    chk("rst_mid state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    bus.alu_ready = 1'b1;
    bus.alu_out = 32'hDEADBEEF;
    wb_seen = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (bus.wb_valid) wb_seen++;
      @(negedge clk);
    end
    bus.alu_ready = 1'b0;
    chk("rst_mid no_wb", wb_seen, 0);
    for (int r = 0; r < 32; r++) model[r] = '0;
    for (int r = 1; r < 32; r++) begin
      dbg_addr = 5'(r);
      #1;
      chk($sformatf("rst_mid x%0d", r), dbg_data, 0);
      @(negedge clk);
    end

    // Random instructions against the register model.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] w, a, b, res;
      logic [4:0] rs1, rs2, rd;
      logic [11:0] imm;
      int kind, k;
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      rd = 5'($urandom_range(0, 31));
      imm = 12'($urandom);
      case ($urandom_range(0, 4))
        0: w = {7'h00, rs2, rs1, 3'd0, rd, 7'h33};
        1: w = {7'h20, rs2, rs1, 3'd0, rd, 7'h33};
        2: w = {7'h00, rs2, rs1, 3'd4, rd, 7'h33};
        3: w = {imm, rs1, 3'd0, rd, 7'h13};
        default: w = $urandom;
      endcase
      kind = op_kind(w);
      a = model[w[19:15]];
      b = (kind == 3) ? {{20{w[31]}}, w[31:20]} : model[w[24:20]];
      case (kind)
        1: res = a - b;
        2: res = a ^ b;
        default: res = a + b;
      endcase
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0: k = 0;
          1: k = MAX_WAIT;
          2: k = MAX_WAIT + 1;
          default: k = MAX_WAIT + 2;
        endcase
      end else begin
        k = $urandom_range(1, 4);
      end
      run_txn($sformatf("rnd%0d", n), w, k, 1'($urandom_range(0, 1)), 1'b0, 32'h0,
              kind < 0, a, b, res);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
# alu_issue

Issue and writeback sequencer that sits directly upstream of the multi-cycle ALU. It accepts one 32-bit RV32I instruction at a time over a valid/ready handshake, decodes it, and reads source operands from an internal 32×32 register file. It drives the ALU's valid/opcode/funct/operand inputs, waits for the ALU's `ready`, and writes the captured result back to `rd`. A watchdog aborts any ALU operation that never completes, and unsupported instructions are flagged and dropped.

## Interface
- `MAX_WAIT`, 16: cycles in WAIT before a timeout abort; legal range 1..255.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `inst_valid`  in  1  upstream offers `inst`.
- `inst_ready`  out  1  block can accept an instruction.
- `inst`  in  32  RV32I instruction word.
- `alu_valid`  out  1  one-cycle start pulse to the ALU.
- `alu_opcode`  out  7  `inst[6:0]` of the held instruction.
- `alu_funct3`  out  3  `inst[14:12]`.
- `alu_funct7`  out  7  `inst[31:25]`.
- `alu_in_A`  out  32  rs1 value.
- `alu_in_B`  out  32  rs2 value (R-type) or sign-extended `inst[31:20]` (ADDI).
- `alu_ready`  in  1  ALU result valid.
- `alu_out`  in  32  ALU result.
- `wb_valid`  out  1  one-cycle pulse when a result is committed.
- `wb_rd`  out  5  destination register of the committed result.
- `wb_data`  out  32  committed value.
- `illegal`  out  1  one-cycle pulse: unsupported instruction dropped.
- `timeout`  out  1  one-cycle pulse: ALU watchdog expired.
- `dbg_addr`  in  5  debug read address.
- `dbg_data`  out  32  combinational register-file read; x0 reads 0.

## Operation
- Supported instructions:
  - ADD: opcode 0110011, f3 000, f7 0000000.
  - SUB: opcode 0110011, f3 000, f7 0100000.
  - XOR: opcode 0110011, f3 100, f7 0000000.
  - ADDI: opcode 0010011, f3 000.
  - Everything else is illegal.
- FSM states and transitions:
  - IDLE: `inst_ready`=1. On `inst_valid`, latch `inst` and go to DECODE.
  - DECODE: if the instruction is illegal, pulse `illegal` and go to IDLE with no write. Otherwise latch the rs1/rs2 register-file reads (and the immediate for ADDI) into operand registers and go to ISSUE.
  - ISSUE: `alu_valid`=1 for exactly this cycle, clear the watchdog counter, go to WAIT.
  - WAIT: the counter increments each cycle.
    - If `alu_ready`=1, capture `alu_out` into `wb_data` and go to WB.
    - Else, if the counter reaches `MAX_WAIT`, pulse `timeout` and go to IDLE with no write.
    - If `alu_ready` and the expiry coincide, `alu_ready` wins.
  - WB: if `rd`≠0, write `wb_data` to `rd`. Pulse `wb_valid` with `wb_rd`=rd (the pulse is issued even when rd=0). Go to IDLE.
- `alu_ready` is ignored outside WAIT.
- `alu_opcode`/`alu_funct*`/`alu_in_*` are registered and stable from ISSUE until the next DECODE.
- x0 is hardwired to zero; writes to x0 are discarded.
- All arithmetic is done by the ALU; this block performs only the 12→32-bit sign extension.

## Timing
- Reset values (asserting `rst_n` low at any time forces all of these immediately):
  - FSM = IDLE; `inst_ready`=1.
  - All pulses, `wb_rd`, `wb_data`, and operand/funct outputs = 0.
  - Watchdog counter = 0; all registers x1..x31 = 0.
- Reset mid-operation abandons the instruction; no write occurs.
- Handshake at cycle 0 → DECODE at cycle 1 → `alu_valid` at cycle 2.
- ALU `ready` sampled at cycle 2+k (k≥1) → `wb_valid` and the register write at cycle 3+k → `inst_ready` high again at cycle 4+k.
- Illegal instruction: `illegal` at cycle 1, `inst_ready` at cycle 2.
- Timeout: `timeout` in the cycle the counter equals `MAX_WAIT`.
- Read-after-write: the write completes at the WB edge, so the next DECODE (at least 2 cycles later) always reads the new value. No bypass is needed.
- Throughput: one instruction in flight; back-to-back `inst_valid` is simply stalled by `inst_ready`=0.

## Structure
- Shared package `alu_pkg`:
  - opcode constants OP_R=7'b0110011 and OP_I=7'b0010011;
  - funct3/funct7 constants for ADD/SUB/XOR/ADDI;
  - the FSM state encoding IDLE/DECODE/ISSUE/WAIT/WB.
- Sub-module `reg_file`: 32×32, two combinational read ports plus the debug port, one synchronous write port, asynchronous active-low clear, x0 fixed at zero.

## Test plan
- ADDI x1,x0,5 (`0x00500093`); ALU model returns `alu_ready` 2 cycles after `alu_valid` with 5 → `alu_in_B`=5, `wb_valid` with rd=1/data=5, `dbg_addr`=1 reads 5.
- ADDI x2,x0,-1 (`0xFFF00113`) → `alu_in_B`=`0xFFFFFFFF`. Then ADD x3,x1,x2 (`0x002081B3`) → `alu_in_A`=5, `alu_in_B`=`0xFFFFFFFF`, `alu_funct7`=0. Model returns 4 → x3=4.
- SUB x4,x1,x2 (`0x40208233`) and XOR x5,x1,x2 (`0x0020C2B3`) sent back-to-back with `inst_valid` held high → second accepted only after the first's `wb_valid`; `alu_funct7`=`0x20` then 0, `alu_funct3`=0 then 4.
- Illegal instruction (`0x00000033`-style OR, f3=110) → `illegal` pulse at cycle 1, no `alu_valid`, register file unchanged.
- ALU model never asserts `alu_ready`, `MAX_WAIT`=16 → `timeout` pulse exactly 16 cycles after entering WAIT, no write. Repeat with `alu_ready` on the expiry cycle → write occurs, no `timeout`.
- ADD x0,x1,x1 → `wb_valid` pulses with rd=0, x0 still reads 0. Separately, drop `rst_n` during WAIT → outputs reset immediately, the later `alu_ready` is ignored, x1..x31 read 0.
